coin_debounce: RTL and testbench
================================

Name: coin_debounce

Overview:
- Input-conditioning stage for the cola vending controller; sits directly upstream of the coin-counting FSM.
- Synchronises the raw mechanical coin-slot contact and debounces it.
- Emits exactly one single-cycle coin pulse per physical coin, plus a reject pulse when coins are locked out.
- Flags a jammed slot (contact held too long) and keeps a wrap-around total of accepted coins.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on coin_raw (minimum 2).
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a level change (minimum 2).
- JAM_CYCLES, 50000000: cycles of stable-high contact after acceptance before jam is declared. Must be > DEBOUNCE_CYCLES.
- CNT_W, 8: width of coin_total.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- coin_raw  input  1  raw coin contact, active-high, asynchronous and bouncy
- accept_en  input  1  1 = coins accepted; 0 = machine locked out, coins rejected
- coin_pulse  output  1  one-cycle pulse per accepted coin; feeds the coin FSM's coin_in
- coin_reject  output  1  one-cycle pulse per coin seen while accept_en = 0
- jam  output  1  level; slot jammed
- coin_total  output  CNT_W  count of accepted coins
- state  output  3  FSM state, for debug

Behaviour:
- Reset (rst = 0, async):
  - All synchroniser flops = 0; state = IDLE; internal counter = 0.
  - coin_pulse = 0, coin_reject = 0, jam = 0, coin_total = 0.
  - Reset mid-operation aborts everything; no pulse is emitted on release of reset.
- Synchroniser: coin_s is the output of the SYNC_STAGES flop chain. Only coin_s is used by the FSM.
- Counter: single shared counter, width = clog2(JAM_CYCLES) + 1.
- State encoding: IDLE = 0, PRESS_WAIT = 1, HELD = 2, RELEASE_WAIT = 3, JAM = 4. Undefined codes go to IDLE.
- IDLE:
  - coin_s = 1 -> PRESS_WAIT, counter <= 1 (first stable sample counted).
- PRESS_WAIT:
  - coin_s = 0 -> IDLE, counter <= 0, no pulse (bounce or glitch).
  - coin_s = 1 and counter == DEBOUNCE_CYCLES-1 -> HELD, counter <= 0. On this same edge:
    - accept_en = 1: coin_pulse <= 1 and coin_total <= coin_total + 1.
    - accept_en = 0: coin_reject <= 1 instead.
  - Otherwise counter++.
- HELD:
  - coin_s = 0 -> RELEASE_WAIT, counter <= 1.
  - coin_s = 1 and counter == JAM_CYCLES-1 -> JAM, jam <= 1.
  - Otherwise counter++.
- JAM:
  - coin_s = 0 -> RELEASE_WAIT, counter <= 1; jam stays 1.
- RELEASE_WAIT:
  - coin_s = 1 (release bounce): return to JAM if jam = 1, else to HELD with counter <= 0. No new pulse.
  - coin_s = 0 and counter == DEBOUNCE_CYCLES-1 -> IDLE, jam <= 0.
  - Otherwise counter++.
- Pulse outputs:
  - coin_pulse and coin_reject are registered, high for exactly one cycle, and never high together.
  - Both are 0 in every cycle not described above.
- Latency: coin_pulse is registered on the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising edge after coin_raw first goes high and stays high.
- accept_en timing: sampled only on the acceptance edge. Changes while in HELD, JAM or RELEASE_WAIT have no effect.
- coin_total: wraps from 2^CNT_W - 1 to 0 with no flag.
- No new coin can be accepted until a full release debounce completes, so at most one pulse per press.

Test Plan (SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, JAM_CYCLES = 20, CNT_W = 8):
1. Clean press: raw held high 30 cycles, accept_en = 1.
   -> coin_pulse registered on the 6th edge after raw rises; high exactly 1 cycle.
   -> coin_total = 1. Returns to IDLE 6 edges after raw falls.
2. Bouncy press: raw toggles 1,0,1,1,0 on successive cycles, then stable 1 for 10 cycles.
   -> Exactly one coin_pulse, 6 edges after the final stable rise; coin_total = 1.
   -> Release bounce 0,1,0 followed by stable 0 -> no extra pulse.
3. Lockout: accept_en = 0, clean press.
   -> coin_reject pulses once; coin_pulse stays 0; coin_total unchanged.
   -> Raise accept_en mid-HELD -> still no pulse.
4. Jam: raw held high 40 cycles.
   -> One coin_pulse, then jam = 1 when counter == 19 in HELD.
   -> After raw low, jam clears on the 4th stable-low sample (entry to IDLE).
5. Wrap: 256 clean presses.
   -> coin_total goes 255 -> 0 on the 256th pulse.
6. Reset mid-press: assert rst while in PRESS_WAIT with counter = 2.
   -> Immediately state = IDLE and all outputs 0.
   -> raw still high after rst release -> exactly one pulse, 6 edges after release.

Source files
------------

// File: rtl/coin_debounce_if.sv
// coin_debounce_if: coin-slot conditioning bus.
//   master (controller side): drives coin_raw, accept_en; observes the outputs.
//   slave  (coin_debounce)  : consumes coin_raw, accept_en; drives
//                             coin_pulse, coin_reject, jam, coin_total, state.
interface coin_debounce_if #(
   parameter int CNT_W = 8
);
   logic             coin_raw;
   logic             accept_en;
   logic             coin_pulse;
   logic             coin_reject;
   logic             jam;
   logic [CNT_W-1:0] coin_total;
   logic [2:0]       state;

   modport master (
      output coin_raw, accept_en,
      input  coin_pulse, coin_reject, jam, coin_total, state
   );

   modport slave (
      input  coin_raw, accept_en,
      output coin_pulse, coin_reject, jam, coin_total, state
   );
endinterface

// File: rtl/coin_debounce.sv
// coin_debounce: synchronises and debounces the raw coin-slot contact.
//   clk, rst (async, active-low)
//   bus.coin_raw    : raw bouncy contact (async)
//   bus.accept_en   : 1 = accept coins, 0 = locked out (sampled at acceptance)
//   bus.coin_pulse  : one-cycle pulse per accepted coin
//   bus.coin_reject : one-cycle pulse per coin seen while locked out
//   bus.jam         : level, contact held high too long
//   bus.coin_total  : wrap-around count of accepted coins
//   bus.state       : FSM state for debug
module coin_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int JAM_CYCLES      = 50000000,
   parameter int CNT_W           = 8
) (
   input  logic           clk,
   input  logic           rst,
   coin_debounce_if.slave bus
);
   localparam int CW = $clog2(JAM_CYCLES) + 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] JAM_LAST = CW'(JAM_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD         = 3'd2,
      RELEASE_WAIT = 3'd3,
      JAM          = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   pulse_q, pulse_d;
   logic                   reject_q, reject_d;
   logic                   jam_q, jam_d;
   logic [CNT_W-1:0]       total_q, total_d;
   logic                   coin_s;

   assign coin_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], bus.coin_raw};
      state_d  = state_q;
      cnt_d    = cnt_q;
      pulse_d  = 1'b0;
      reject_d = 1'b0;
      jam_d    = jam_q;
      total_d  = total_q;
      case (state_q)
         IDLE: begin
            if (coin_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = CW'(1);   // this sample is the first stable one
            end
         end
         PRESS_WAIT: begin
            if (!coin_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               // accept_en matters only on this edge
               if (bus.accept_en) begin
                  pulse_d = 1'b1;
                  total_d = total_q + 1'b1;
               end else begin
                  reject_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HELD: begin
            if (!coin_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CW'(1);
            end else if (cnt_q == JAM_LAST) begin
               state_d = JAM;
               jam_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         JAM: begin
            if (!coin_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CW'(1);
            end
         end
         RELEASE_WAIT: begin
            if (coin_s) begin
               // release bounce: fall back to the held-side state, no new coin
               state_d = jam_q ? JAM : HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               jam_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q   <= '0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         pulse_q  <= 1'b0;
         reject_q <= 1'b0;
         jam_q    <= 1'b0;
         total_q  <= '0;
      end else begin
         sync_q   <= sync_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pulse_q  <= pulse_d;
         reject_q <= reject_d;
         jam_q    <= jam_d;
         total_q  <= total_d;
      end
   end

   assign bus.coin_pulse  = pulse_q;
   assign bus.coin_reject = reject_q;
   assign bus.jam         = jam_q;
   assign bus.coin_total  = total_q;
   assign bus.state       = state_q;
endmodule

// File: tb/tb_coin_debounce.sv
// tb_coin_debounce: directed test-plan scenarios plus randomized contact
// waveforms, checked each cycle against a run-length reference model.
module tb_coin_debounce;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int JAMC = 20;
   localparam int CW   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   coin_debounce_if #(.CNT_W(CW)) bus ();

   coin_debounce #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .JAM_CYCLES(JAMC), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int n_pulse = 0;
   int n_rej = 0;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: the contact is "pressed" once the delayed contact has
   // shown DEB consecutive highs while unlatched; it is released after DEB
   // consecutive lows. Jam fires after JAMC further highs following the
   // acceptance sample or the latest release-bounce sample.
   logic       m_hist [SYNC] = '{default: 1'b0};
   bit         m_lat = 0, m_jam = 0, m_last = 0, m_pulse = 0, m_rej = 0;
   int         m_run1 = 0, m_run0 = 0, m_hi = 0;
   logic [7:0] m_total = '0;

   always @(posedge clk or negedge rst) begin
      bit s;
      if (!rst) begin
         m_hist  = '{default: 1'b0};
         m_lat   = 0; m_jam = 0; m_last = 0; m_pulse = 0; m_rej = 0;
         m_run1  = 0; m_run0 = 0; m_hi = 0; m_total = '0;
      end else begin
         s = m_hist[SYNC-1];
         for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = bus.coin_raw;
         m_pulse = 0; m_rej = 0; m_last = s;
         if (s) begin m_run1++; m_run0 = 0; end
         else   begin m_run0++; m_run1 = 0; end
         if (!m_lat) begin
            if (s && m_run1 == DEB) begin
               m_lat = 1; m_hi = 0;
               if (bus.accept_en) begin m_pulse = 1; m_total = m_total + 8'd1; end
               else m_rej = 1;
            end
         end else if (s) begin
            if (!m_jam) begin
               if (m_run1 == 1) m_hi = 0;
               else begin
                  m_hi++;
                  if (m_hi == JAMC) m_jam = 1;
               end
            end
         end else if (m_run0 == DEB) begin
            m_lat = 0; m_jam = 0;
         end
      end
   end

   always @(negedge clk) begin
      int es;
      if (!m_lat)      es = (m_run1 > 0) ? 1 : 0;
      else if (m_last) es = m_jam ? 4 : 2;
      else             es = 3;
      chk("pulse",  int'(bus.coin_pulse),  int'(m_pulse));
      chk("reject", int'(bus.coin_reject), int'(m_rej));
      chk("jam",    int'(bus.jam),         int'(m_jam));
      chk("total",  int'(bus.coin_total),  int'(m_total));
      chk("state",  int'(bus.state),       es);
      chk("excl",   int'(bus.coin_pulse & bus.coin_reject), 0);
      n_pulse += int'(bus.coin_pulse);
      n_rej   += int'(bus.coin_reject);
   end

   logic sq[$];

   task automatic fill(input logic v, input int n);
      for (int i = 0; i < n; i++) sq.push_back(v);
   endtask

   // Plays sq one value per cycle; reports first pulse edge and pulse/reject counts.
   task automatic run_sq(output int pe, output int np, output int nr);
      int p0, r0;
      p0 = n_pulse; r0 = n_rej; pe = -1;
      foreach (sq[i]) begin
         bus.coin_raw = sq[i];
         @(posedge clk); @(negedge clk); #1;
         if (bus.coin_pulse && pe < 0) pe = i + 1;
      end
      np = n_pulse - p0; nr = n_rej - r0;
      sq.delete();
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_pulse"}, int'(bus.coin_pulse), 0);
      chk({tag, "_rej"},   int'(bus.coin_reject), 0);
      chk({tag, "_jam"},   int'(bus.jam), 0);
      chk({tag, "_total"}, int'(bus.coin_total), 0);
      chk({tag, "_state"}, int'(bus.state), 0);
   endtask

   task automatic do_reset();
      rst = 1'b0; #1;
      chk_reset_outs("rst");
      repeat (2) @(negedge clk);
      rst = 1'b1; #1;
   endtask

   initial begin
      int pe, np, nr, ie;
      bus.coin_raw = 1'b0; bus.accept_en = 1'b1;
      #1 do_reset();
      fill(0, 4); run_sq(pe, np, nr);

      // 1: clean press
      fill(1, 30); run_sq(pe, np, nr);
      chk("t1_lat", pe, 6);
      chk("t1_total", int'(bus.coin_total), 1);
      ie = -1;
      for (int i = 1; i <= 10; i++) begin
         bus.coin_raw = 1'b0;
         @(posedge clk); @(negedge clk); #1;
         if (bus.state == 3'd0 && ie < 0) ie = i;
      end
      chk("t1_idle", ie, 6);
      chk("t1_np", n_pulse, 1);

      // 2: bouncy press and release
      sq = '{1, 0, 1, 1, 0}; fill(1, 10);
      sq.push_back(0); sq.push_back(1); sq.push_back(0); fill(0, 10);
      run_sq(pe, np, nr);
      chk("t2_lat", pe, 11);
      chk("t2_np", np, 1);
      chk("t2_total", int'(bus.coin_total), 2);

      // 3: lockout, accept_en raised mid-HELD
      bus.accept_en = 1'b0;
      fill(1, 8); run_sq(pe, np, nr);
      chk("t3_rej_a", nr, 1);
      bus.accept_en = 1'b1;
      fill(1, 4); fill(0, 10); run_sq(pe, ie, nr);
      chk("t3_np", np + ie, 0);
      chk("t3_rej_b", nr, 0);
      chk("t3_total", int'(bus.coin_total), 2);

      // 4: jam
      fill(1, 40); run_sq(pe, np, nr);
      chk("t4_np", np, 1);
      chk("t4_jam_set", int'(bus.jam), 1);
      fill(0, 5); run_sq(pe, np, nr);
      chk("t4_jam_hold", int'(bus.jam), 1);
      fill(0, 1); run_sq(pe, np, nr);
      chk("t4_jam_clr", int'(bus.jam), 0);
      fill(0, 4); run_sq(pe, np, nr);

      // 5: wrap
      do_reset();
      for (int k = 0; k < 255; k++) begin fill(1, 6); fill(0, 7); end
      run_sq(pe, np, nr);
      chk("t5_np", np, 255);
      chk("t5_255", int'(bus.coin_total), 255);
      fill(1, 6); fill(0, 7); run_sq(pe, np, nr);
      chk("t5_wrap", int'(bus.coin_total), 0);
      fill(1, 6); fill(0, 7); run_sq(pe, np, nr);
      chk("t5_after", int'(bus.coin_total), 1);

      // 6: reset mid-press
      fill(1, 4); run_sq(pe, np, nr);
      chk("t6_pre", int'(bus.state), 1);
      do_reset();
      fill(1, 12); run_sq(pe, np, nr);
      chk("t6_lat", pe, 6);
      chk("t6_np", np, 1);
      fill(0, 8); run_sq(pe, np, nr);

      // randomized waveforms, model-checked every cycle
      for (int it = 0; it < 60; it++) begin
         bus.accept_en = 1'($urandom_range(0, 1));
         for (int i = 0; i < int'($urandom_range(0, 5)); i++) sq.push_back(1'($urandom_range(0, 1)));
         fill(1, $urandom_range(1, 45));
         run_sq(pe, np, nr);
         if ($urandom_range(0, 2) == 0) bus.accept_en = ~bus.accept_en;
         for (int i = 0; i < int'($urandom_range(0, 4)); i++) sq.push_back(1'($urandom_range(0, 1)));
         fill(0, $urandom_range(1, 12));
         run_sq(pe, np, nr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
